// File: rtl/oht2bin_pkg.sv
// Shared constants, tree-shape helpers and node record for the one-hot to binary tree.
// Latency: none (package only).
// Backpressure: not applicable.
//
// levels(width, split) : depth of a split-ary tree over width leaves
// clog2(split)         : index bits contributed per tree level
// node_t               : {any, err, idx} record, sized for the widest supported index
package oht2bin_pkg;

    // Widest index a node_t can carry; 16 bits covers trees up to 64K leaves.
    localparam int MAX_IDX_W = 16;

    function automatic int clog2(input int split);
        int r = 0;
        while ((1 << r) < split) begin
            r++;
        end
        return r;
    endfunction

    function automatic int levels(input int width, input int split);
        int l = 0;
        int w = width;
        while (w > 1) begin
            w = w / split;
            l++;
        end
        return l;
    endfunction

    typedef struct packed {
        logic                 any;
        logic                 err;
        logic [MAX_IDX_W-1:0] idx;
    } node_t;

endpackage

// File: rtl/oht2bin_node.sv
// One SPLIT-input reduction node: merges child {any, err, idx} records into a parent record.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline stage decides when the result is captured.
//
// c_dat_i : SPLIT child words, child c at [c*CW +: CW], laid out as {any, err, idx[CIW-1:0]}
// any_o   : OR of child any bits
// err_o   : OR of child err bits, or more than one child with any set
// idx_o   : {index of child with any set, OR of child idx masked by child any}
module oht2bin_node
    import oht2bin_pkg::*;
#(
    parameter int  SPLIT = 2,
    parameter int  CIW   = 0,
    localparam int LS    = clog2(SPLIT),
    localparam int CW    = CIW + 2
) (
    input  logic [SPLIT*CW-1:0] c_dat_i,
    output logic                any_o,
    output logic                err_o,
    output logic [CIW+LS-1:0]   idx_o
);

    logic [SPLIT-1:0] ch_any;
    logic [SPLIT-1:0] ch_err;
    logic [LS-1:0]    hi;

    for (genvar c = 0; c < SPLIT; c++) begin : g_ch
        assign ch_any[c] = c_dat_i[c*CW + CW - 1];
        assign ch_err[c] = c_dat_i[c*CW + CW - 2];
    end

    // Child positions are OR-ed rather than priority-selected, so a multi-hot
    // input yields the OR of all set-bit indexes instead of an arbitrary pick.
    always_comb begin
        hi = '0;
        for (int c = 0; c < SPLIT; c++) begin
            if (ch_any[c]) begin
                hi = hi | LS'(c);
            end
        end
    end

    assign any_o = |ch_any;
    // x & (x-1) is non-zero exactly when two or more bits of x are set.
    assign err_o = (|ch_err) || ((ch_any & (ch_any - 1'b1)) != '0);

    if (CIW > 0) begin : g_lo
        logic [CIW-1:0] lo;

        always_comb begin
            lo = '0;
            for (int c = 0; c < SPLIT; c++) begin
                lo = lo | (c_dat_i[c*CW +: CIW] & {CIW{ch_any[c]}});
            end
        end

        assign idx_o = {hi, lo};
    end else begin : g_leaf
        assign idx_o = hi;
    end

endmodule

// File: rtl/oht2bin_pipe_tree.sv
// Pipelined one-hot to binary encoder: SPLIT-ary reduction tree, one register stage per level.
// Latency: LEVELS cycles with ordy high; one transaction per cycle, no bubbles.
// Backpressure: per-stage valid/ready chain; stages fill while ordy is low, irdy falls only when all are full.
//
// clk, rst       : clock (rising edge), asynchronous active-high reset
// oht, ivld/irdy : input vector and its handshake
// bin, any, err  : binary index, any-bit-set flag, more-than-one-bit flag
// ovld/ordy      : output handshake
module oht2bin_pipe_tree
    import oht2bin_pkg::*;
#(
    parameter int  WIDTH  = 32,
    parameter int  SPLIT  = 2,
    localparam int LEVELS = levels(WIDTH, SPLIT),
    localparam int LS     = clog2(SPLIT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         oht,
    input  logic                     ivld,
    output logic                     irdy,
    output logic [$clog2(WIDTH)-1:0] bin,
    output logic                     any,
    output logic                     err,
    output logic                     ovld,
    input  logic                     ordy
);

    localparam int BW = LEVELS * LS;

    // ------------------------------------------------------------------
    // Handshake chain
    // ------------------------------------------------------------------
    logic [LEVELS-1:0] vld_q;
    logic [LEVELS-1:0] vld_d;
    logic [LEVELS:0]   rdy;
    logic [LEVELS-1:0] in_vld;
    logic [LEVELS-1:0] load;

    assign rdy[LEVELS] = ordy;
    assign in_vld[0]   = ivld;

    for (genvar k = 0; k < LEVELS; k++) begin : g_rdy
        // A stage can accept when empty or when its content moves on this cycle.
        assign rdy[k] = !vld_q[k] || rdy[k+1];
    end

    for (genvar k = 1; k < LEVELS; k++) begin : g_ivld
        assign in_vld[k] = vld_q[k-1];
    end

    // Data only loads on a real transfer, so bubbles leave held data untouched.
    assign load = rdy[LEVELS-1:0] & in_vld;

    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < LEVELS; k++) begin
            if (rdy[k]) begin
                vld_d[k] = in_vld[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Reduction tree, one registered level per stage.
    // Each node word is {any, err, idx}; level k has WIDTH/SPLIT**(k+1) nodes
    // with (k+1)*LS index bits, which is exactly the child word of level k+1.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NN  = WIDTH / (SPLIT ** (k + 1));
        localparam int CIW = k * LS;
        localparam int CW  = CIW + 2;
        localparam int OW  = (k + 1) * LS;
        localparam int NW  = OW + 2;

        wire  [NN*SPLIT*CW-1:0] c_dat;
        wire  [NN*NW-1:0]       n_d;
        logic [NN*NW-1:0]       n_q;

        if (k == 0) begin : g_src
            // Leaves: any is the raw bit, err is never set by a single bit.
            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                assign c_dat[b*2 +: 2] = {oht[b], 1'b0};
            end
        end else begin : g_src
            assign c_dat = g_lvl[k-1].n_q;
        end

        for (genvar j = 0; j < NN; j++) begin : g_node
            oht2bin_node #(
                .SPLIT (SPLIT),
                .CIW   (CIW)
            ) u_node (
                .c_dat_i (c_dat[j*SPLIT*CW +: SPLIT*CW]),
                .any_o   (n_d[j*NW + NW - 1]),
                .err_o   (n_d[j*NW + NW - 2]),
                .idx_o   (n_d[j*NW +: OW])
            );
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                n_q <= '0;
            end else if (load[k]) begin
                n_q <= n_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign irdy = rdy[0];
    assign ovld = vld_q[LEVELS-1];
    assign any  = g_lvl[LEVELS-1].n_q[BW+1];
    assign err  = g_lvl[LEVELS-1].n_q[BW];
    assign bin  = g_lvl[LEVELS-1].n_q[BW-1:0];

endmodule
